// File: rtl/mor1kx_store_drain_pkg.sv
// Shared types for the store-buffer drain engine.
package mor1kx_store_drain_pkg;

  // Drain FSM states.
  typedef enum logic [1:0] {
    SD_IDLE  = 2'd0,
    SD_FETCH = 2'd1,
    SD_WRITE = 2'd2,
    SD_ERR   = 2'd3
  } sd_state_e;

  // Byte-select width for a given operand width.
  function automatic int sd_bsel_width(input int ow);
    return ow / 8;
  endfunction

endpackage

// File: rtl/mor1kx_store_drain.sv
// Store-buffer drain: pops one entry at a time, issues a single write per
// entry on the data bus and captures PC/address of a store that faults.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SD_IDLE  | nothing in flight; pop as soon as the buffer is non-empty
// SD_FETCH | popped entry is on sb_* this cycle; capture it
// SD_WRITE | write request held on the bus until ack or err
// SD_ERR   | faulting store reported; drain halted until err_clear_i
module mor1kx_store_drain
  import mor1kx_store_drain_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_dat_i,
  input  logic [OPTION_OPERAND_WIDTH/8-1:0] sb_bsel_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_pc_i,
  input  logic                              sb_atomic_i,
  input  logic                              sb_empty_i,
  output logic                              sb_read_o,
  output logic                              dbus_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0] dbus_bsel_o,
  output logic                              dbus_atomic_o,
  input  logic                              dbus_ack_i,
  input  logic                              dbus_err_i,
  output logic                              store_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   err_pc_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   err_adr_o,
  input  logic                              err_clear_i,
  output logic                              busy_o
);

  localparam int OW = OPTION_OPERAND_WIDTH;
  localparam int BW = sd_bsel_width(OPTION_OPERAND_WIDTH);

  sd_state_e         state_q, state_d;
  logic              req_q, req_d;
  logic [OW-1:0]     adr_q, adr_d;
  logic [OW-1:0]     dat_q, dat_d;
  logic [BW-1:0]     bsel_q, bsel_d;
  logic [OW-1:0]     pc_q, pc_d;
  logic              atomic_q, atomic_d;
  logic [OW-1:0]     err_pc_q, err_pc_d;
  logic [OW-1:0]     err_adr_q, err_adr_d;
  logic              sb_read;

  // Next-state, entry capture, error capture and pop strobe.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    bsel_d    = bsel_q;
    pc_d      = pc_q;
    atomic_d  = atomic_q;
    err_pc_d  = err_pc_q;
    err_adr_d = err_adr_q;
    sb_read   = 1'b0;

    case (state_q)
      SD_IDLE: begin
        if (!sb_empty_i) begin
          sb_read = 1'b1;
          state_d = SD_FETCH;
        end
      end
      SD_FETCH: begin
        adr_d    = sb_adr_i;
        dat_d    = sb_dat_i;
        bsel_d   = sb_bsel_i;
        pc_d     = sb_pc_i;
        atomic_d = sb_atomic_i;
        req_d    = 1'b1;
        state_d  = SD_WRITE;
      end
      SD_WRITE: begin
        // Error takes priority over a simultaneous ack.
        if (dbus_err_i) begin
          req_d     = 1'b0;
          err_pc_d  = pc_q;
          err_adr_d = adr_q;
          state_d   = SD_ERR;
        end else if (dbus_ack_i) begin
          req_d = 1'b0;
          if (!sb_empty_i) begin
            sb_read = 1'b1;
            state_d = SD_FETCH;
          end else begin
            state_d = SD_IDLE;
          end
        end
      end
      SD_ERR: begin
        if (err_clear_i) begin
          state_d = SD_IDLE;
        end
      end
      default: begin
        state_d = SD_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State, request and entry/error registers; reset drops the in-flight entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SD_IDLE;
      req_q     <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      bsel_q    <= '0;
      pc_q      <= '0;
      atomic_q  <= 1'b0;
      err_pc_q  <= '0;
      err_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      bsel_q    <= bsel_d;
      pc_q      <= pc_d;
      atomic_q  <= atomic_d;
      err_pc_q  <= err_pc_d;
      err_adr_q <= err_adr_d;
    end
  end

  // Pop is held off during reset so the buffer never sees a stray strobe.
  assign sb_read_o     = sb_read & !rst;
  assign dbus_req_o    = req_q;
  assign dbus_adr_o    = adr_q;
  assign dbus_dat_o    = dat_q;
  assign dbus_bsel_o   = bsel_q;
  assign dbus_atomic_o = atomic_q;
  assign store_err_o   = (state_q == SD_ERR);
  assign err_pc_o      = err_pc_q;
  assign err_adr_o     = err_adr_q;
  assign busy_o        = ((state_q != SD_IDLE) && (state_q != SD_ERR)) || !sb_empty_i;

endmodule

// File: tb/tb_mor1kx_store_drain.sv
// Directed bench for the store-buffer drain engine.
module tb_mor1kx_store_drain;

  logic        clk;
  logic        rst;
  logic [31:0] sb_adr_i    = 32'hBAD0_0000;
  logic [31:0] sb_dat_i    = 32'hBAD1_1111;
  logic [3:0]  sb_bsel_i   = 4'h5;
  logic [31:0] sb_pc_i     = 32'hBAD2_2222;
  logic        sb_atomic_i = 1'b1;
  logic        sb_empty_i;
  logic        sb_read_o;
  logic        dbus_req_o;
  logic [31:0] dbus_adr_o;
  logic [31:0] dbus_dat_o;
  logic [3:0]  dbus_bsel_o;
  logic        dbus_atomic_o;
  logic        dbus_ack_i;
  logic        dbus_err_i;
  logic        store_err_o;
  logic [31:0] err_pc_o;
  logic [31:0] err_adr_o;
  logic        err_clear_i;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  bsel;
    logic [31:0] pc;
    logic        atomic;
  } ent_t;

  ent_t q[$];
  int   sb_cnt = 0;
  logic rd_lat = 1'b0;

  assign sb_empty_i = (sb_cnt == 0);

  mor1kx_store_drain #(.OPTION_OPERAND_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .sb_adr_i     (sb_adr_i),
    .sb_dat_i     (sb_dat_i),
    .sb_bsel_i    (sb_bsel_i),
    .sb_pc_i      (sb_pc_i),
    .sb_atomic_i  (sb_atomic_i),
    .sb_empty_i   (sb_empty_i),
    .sb_read_o    (sb_read_o),
    .dbus_req_o   (dbus_req_o),
    .dbus_adr_o   (dbus_adr_o),
    .dbus_dat_o   (dbus_dat_o),
    .dbus_bsel_o  (dbus_bsel_o),
    .dbus_atomic_o(dbus_atomic_o),
    .dbus_ack_i   (dbus_ack_i),
    .dbus_err_i   (dbus_err_i),
    .store_err_o  (store_err_o),
    .err_pc_o     (err_pc_o),
    .err_adr_o    (err_adr_o),
    .err_clear_i  (err_clear_i),
    .busy_o       (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Store buffer model: pop strobe sampled mid-low-phase, entry shown for one cycle.
  always @(negedge clk) begin
    #2;
    rd_lat = sb_read_o;
  end

  always @(posedge clk) begin
    ent_t e;
    #1;
    if (rd_lat && q.size() > 0) begin
      e           = q.pop_front();
      sb_adr_i    = e.adr;
      sb_dat_i    = e.dat;
      sb_bsel_i   = e.bsel;
      sb_pc_i     = e.pc;
      sb_atomic_i = e.atomic;
    end else begin
      sb_adr_i    = 32'hBAD0_0000;
      sb_dat_i    = 32'hBAD1_1111;
      sb_bsel_i   = 4'h5;
      sb_pc_i     = 32'hBAD2_2222;
      sb_atomic_i = 1'b1;
    end
    sb_cnt = q.size();
  end

  task automatic push(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] bsel,
                      input logic [31:0] pc, input logic atomic);
    ent_t e;
    e.adr = adr; e.dat = dat; e.bsel = bsel; e.pc = pc; e.atomic = atomic;
    q.push_back(e);
    sb_cnt = q.size();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    dbus_ack_i = 1'b0;
    dbus_err_i = 1'b0;
    err_clear_i = 1'b0;

    // Reset state
    cyc(); cyc(); #1;
    chk("rst_req", dbus_req_o, 0);
    chk("rst_adr", dbus_adr_o, 0);
    chk("rst_dat", dbus_dat_o, 0);
    chk("rst_bsel", dbus_bsel_o, 0);
    chk("rst_atomic", dbus_atomic_o, 0);
    chk("rst_store_err", store_err_o, 0);
    chk("rst_err_pc", err_pc_o, 0);
    chk("rst_err_adr", err_adr_o, 0);
    chk("rst_read", sb_read_o, 0);
    chk("rst_busy", busy_o, 0);
    cyc(); rst = 1'b0;

    // Single store, ack in third WRITE cycle
    cyc(); push(32'h1000, 32'hDEADBEEF, 4'hF, 32'h0100, 1'b0); #1;
    chk("s1_read", sb_read_o, 1);
    chk("s1_req_idle", dbus_req_o, 0);
    chk("s1_busy", busy_o, 1);
    cyc(); #1;
    chk("s1_fetch_read", sb_read_o, 0);
    chk("s1_fetch_req", dbus_req_o, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) dbus_ack_i = 1'b1;
      #1;
      chk("s1_req", dbus_req_o, 1);
      chk("s1_adr", dbus_adr_o, 32'h1000);
      chk("s1_dat", dbus_dat_o, 32'hDEADBEEF);
      chk("s1_bsel", dbus_bsel_o, 4'hF);
      chk("s1_wr_read", sb_read_o, 0);
    end
    cyc(); dbus_ack_i = 1'b0; #1;
    chk("s1_done_req", dbus_req_o, 0);
    chk("s1_done_busy", busy_o, 0);
    chk("s1_done_read", sb_read_o, 0);

    // Back-to-back, four entries, ack in first WRITE cycle
    cyc();
    for (int i = 0; i < 4; i++)
      push(32'h1100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'(1 << i), 32'h0200 + 32'(4 * i), 1'b0);
    #1;
    chk("b2b_read0", sb_read_o, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(); dbus_ack_i = 1'b0; #1;
      chk("b2b_fetch_req", dbus_req_o, 0);
      chk("b2b_fetch_read", sb_read_o, 0);
      cyc(); dbus_ack_i = 1'b1; #1;
      chk("b2b_req", dbus_req_o, 1);
      chk("b2b_adr", dbus_adr_o, 32'h1100 + 32'(4 * i));
      chk("b2b_dat", dbus_dat_o, 32'hA000_0000 + 32'(i));
      chk("b2b_bsel", dbus_bsel_o, 32'(1 << i));
      chk("b2b_read_ack", sb_read_o, (i < 3) ? 32'd1 : 32'd0);
    end
    cyc(); dbus_ack_i = 1'b0; #1;
    chk("b2b_done_req", dbus_req_o, 0);
    chk("b2b_done_busy", busy_o, 0);

    // Bus error on second of three entries
    cyc();
    push(32'h3004, 32'h11111111, 4'hF, 32'h2000, 1'b0);
    push(32'h3008, 32'h22222222, 4'hF, 32'h2004, 1'b0);
    push(32'h300C, 32'h33333333, 4'hF, 32'h2008, 1'b0);
    #1;
    chk("err_read0", sb_read_o, 1);
    cyc(); #1;
    cyc(); dbus_ack_i = 1'b1; #1;
    chk("err_adr0", dbus_adr_o, 32'h3004);
    chk("err_read1", sb_read_o, 1);
    cyc(); dbus_ack_i = 1'b0; #1;
    cyc(); dbus_err_i = 1'b1; #1;
    chk("err_adr1", dbus_adr_o, 32'h3008);
    chk("err_read_on_err", sb_read_o, 0);
    cyc(); dbus_err_i = 1'b0; #1;
    chk("err_flag", store_err_o, 1);
    chk("err_pc", err_pc_o, 32'h2004);
    chk("err_adr", err_adr_o, 32'h3008);
    chk("err_req", dbus_req_o, 0);
    chk("err_busy", busy_o, 1);
    chk("err_read", sb_read_o, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      chk("err_hold_read", sb_read_o, 0);
      chk("err_hold_req", dbus_req_o, 0);
    end
    cyc(); err_clear_i = 1'b1; #1;
    chk("err_clear_read", sb_read_o, 0);
    cyc(); err_clear_i = 1'b0; #1;
    chk("err_cleared_flag", store_err_o, 0);
    chk("err_cleared_read", sb_read_o, 1);
    chk("err_pc_kept", err_pc_o, 32'h2004);
    cyc(); #1;
    cyc(); dbus_ack_i = 1'b1; #1;
    chk("err_third_req", dbus_req_o, 1);
    chk("err_third_adr", dbus_adr_o, 32'h300C);
    chk("err_third_dat", dbus_dat_o, 32'h33333333);
    cyc(); dbus_ack_i = 1'b0; #1;
    chk("err_done_busy", busy_o, 0);

    // Simultaneous ack and err
    cyc();
    push(32'h4000, 32'h44444444, 4'h3, 32'h5000, 1'b0);
    push(32'h4004, 32'h55555555, 4'hC, 32'h5004, 1'b0);
    #1;
    chk("ae_read0", sb_read_o, 1);
    cyc(); #1;
    cyc(); dbus_ack_i = 1'b1; dbus_err_i = 1'b1; #1;
    chk("ae_req", dbus_req_o, 1);
    chk("ae_read", sb_read_o, 0);
    cyc(); dbus_ack_i = 1'b0; dbus_err_i = 1'b0; #1;
    chk("ae_flag", store_err_o, 1);
    chk("ae_err_adr", err_adr_o, 32'h4000);
    chk("ae_err_pc", err_pc_o, 32'h5000);
    chk("ae_req_off", dbus_req_o, 0);
    cyc(); err_clear_i = 1'b1; #1;
    cyc(); err_clear_i = 1'b0; #1;
    chk("ae_resume_read", sb_read_o, 1);
    cyc(); #1;
    cyc(); #1;
    chk("ae_stall_req", dbus_req_o, 1);
    chk("ae_stall_adr", dbus_adr_o, 32'h4004);

    // Reset while the bus is stalled
    cyc(); rst = 1'b1; q.delete(); sb_cnt = 0; #1;
    chk("mrst_req", dbus_req_o, 0);
    chk("mrst_adr", dbus_adr_o, 0);
    chk("mrst_bsel", dbus_bsel_o, 0);
    chk("mrst_store_err", store_err_o, 0);
    chk("mrst_err_adr", err_adr_o, 0);
    chk("mrst_err_pc", err_pc_o, 0);
    chk("mrst_busy", busy_o, 0);
    chk("mrst_read", sb_read_o, 0);
    cyc(); cyc(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("mrst_no_req", dbus_req_o, 0);
      chk("mrst_no_read", sb_read_o, 0);
    end

    // Atomic passthrough
    cyc();
    push(32'h6000, 32'h66666666, 4'hF, 32'h7000, 1'b1);
    push(32'h6004, 32'h77777777, 4'hF, 32'h7004, 1'b0);
    #1;
    cyc(); #1;
    cyc(); #1;
    chk("at_req0", dbus_req_o, 1);
    chk("at_atomic0", dbus_atomic_o, 1);
    cyc(); dbus_ack_i = 1'b1; #1;
    chk("at_atomic0_hold", dbus_atomic_o, 1);
    chk("at_adr0", dbus_adr_o, 32'h6000);
    cyc(); dbus_ack_i = 1'b0; #1;
    cyc(); dbus_ack_i = 1'b1; #1;
    chk("at_req1", dbus_req_o, 1);
    chk("at_adr1", dbus_adr_o, 32'h6004);
    chk("at_atomic1", dbus_atomic_o, 0);
    cyc(); dbus_ack_i = 1'b0; #1;
    chk("at_done_req", dbus_req_o, 0);
    chk("at_done_busy", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
